// File: rtl/bus_arbiter_nm.sv
// N-master system bus arbiter: fixed-priority or round-robin grant, one
// outstanding split transaction, and an optional grant-length timeout.
module bus_arbiter_nm #(
    parameter  int NUM_MASTERS = 2,
    parameter  int RR_MODE     = 0,
    parameter  int TIMEOUT     = 0,
    localparam int IDW         = (NUM_MASTERS > 2) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_MASTERS-1:0] breq,
    input  logic                   split_req,
    input  logic                   split_release,
    output logic [NUM_MASTERS-1:0] bgrant,
    output logic [NUM_MASTERS-1:0] msplit,
    output logic [IDW-1:0]         owner_id,
    output logic                   bus_busy,
    output logic                   timeout_evt
);

    localparam int            CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_GRANT = 1'b1;

    logic [0:0]             state_q,  state_d;
    logic [NUM_MASTERS-1:0] bgrant_q, bgrant_d;
    logic [NUM_MASTERS-1:0] msplit_q, msplit_d;
    logic [NUM_MASTERS-1:0] excl_q,   excl_d;
    logic [IDW-1:0]         owner_q,  owner_d;
    logic [IDW-1:0]         ptr_q,    ptr_d;
    logic [CW-1:0]          cnt_q,    cnt_d;
    logic                   resume_q, resume_d;
    logic                   tevt_q,   tevt_d;

    logic [NUM_MASTERS-1:0] eligible;
    logic                   split_pend;
    logic                   resume_now;
    logic                   split_ready;
    logic                   owner_req;
    logic                   others_wait;

    assign eligible    = breq & ~msplit_q & ~excl_q;
    assign split_pend  = |msplit_q;
    // A release pulse arriving while idle resumes the split master in the same arbitration.
    assign resume_now  = resume_q | (split_release & split_pend);
    assign split_ready = |(breq & msplit_q);
    assign owner_req   = |(breq & bgrant_q);
    assign others_wait = |(eligible & ~bgrant_q);

    logic [NUM_MASTERS-1:0] fp_vec;
    logic [IDW-1:0]         fp_idx;
    logic                   fp_found;

    // NOTE: blocking assignments in combinational logic let the found flag
    // suppress later loop iterations; registers below use non-blocking only.
    always_comb begin
        fp_vec   = '0;
        fp_idx   = '0;
        fp_found = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (!fp_found && eligible[i]) begin
                fp_found  = 1'b1;
                fp_vec[i] = 1'b1;
                fp_idx    = IDW'(i);
            end
        end
    end

    logic [NUM_MASTERS-1:0] rr_vec;
    logic [IDW-1:0]         rr_idx;
    logic                   rr_found;
    logic [IDW-1:0]         cand_idx;
    int                     cand;

    always_comb begin
        rr_vec   = '0;
        rr_idx   = '0;
        rr_found = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            cand     = (int'(ptr_q) + k) % NUM_MASTERS;
            cand_idx = IDW'(cand);
            if (!rr_found && eligible[cand_idx]) begin
                rr_found         = 1'b1;
                rr_vec[cand_idx] = 1'b1;
                rr_idx           = cand_idx;
            end
        end
    end

    logic [IDW-1:0] sp_idx;

    always_comb begin
        sp_idx = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (msplit_q[i]) sp_idx = IDW'(i);
        end
    end

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        bgrant_d = bgrant_q;
        msplit_d = msplit_q;
        excl_d   = excl_q;
        owner_d  = owner_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        resume_d = resume_q;
        tevt_d   = 1'b0;

        if (split_release && split_pend) resume_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (resume_now && split_ready) begin
                    bgrant_d = msplit_q;
                    owner_d  = sp_idx;
                    msplit_d = '0;
                    resume_d = 1'b0;
                    excl_d   = '0;
                    cnt_d    = '0;
                    state_d  = S_GRANT;
                end else if (RR_MODE == 0 && fp_found) begin
                    bgrant_d = fp_vec;
                    owner_d  = fp_idx;
                    excl_d   = '0;
                    cnt_d    = '0;
                    state_d  = S_GRANT;
                end else if (RR_MODE != 0 && rr_found) begin
                    bgrant_d = rr_vec;
                    owner_d  = rr_idx;
                    ptr_d    = rr_idx;
                    excl_d   = '0;
                    cnt_d    = '0;
                    state_d  = S_GRANT;
                end
            end
            S_GRANT: begin
                // Split beats both a simultaneous release and a timeout.
                if (split_req && !split_pend) begin
                    msplit_d = bgrant_q;
                    bgrant_d = '0;
                    owner_d  = '0;
                    state_d  = S_IDLE;
                end else if (!owner_req) begin
                    bgrant_d = '0;
                    owner_d  = '0;
                    state_d  = S_IDLE;
                end else if ((TIMEOUT > 0) && (cnt_q == CNT_LAST)) begin
                    excl_d   = bgrant_q;
                    tevt_d   = 1'b1;
                    bgrant_d = '0;
                    owner_d  = '0;
                    state_d  = S_IDLE;
                end else if (others_wait && (cnt_q != CNT_MAX)) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d  = S_IDLE;
                bgrant_d = '0;
                owner_d  = '0;
            end
        endcase
    end

    // NOTE: all state, including the split and exclusion bookkeeping, is
    // reset so a mid-transaction reset discards any outstanding split.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            bgrant_q <= '0;
            msplit_q <= '0;
            excl_q   <= '0;
            owner_q  <= '0;
            ptr_q    <= IDW'(NUM_MASTERS - 1);
            cnt_q    <= '0;
            resume_q <= 1'b0;
            tevt_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            bgrant_q <= bgrant_d;
            msplit_q <= msplit_d;
            excl_q   <= excl_d;
            owner_q  <= owner_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            resume_q <= resume_d;
            tevt_q   <= tevt_d;
        end
    end

    assign bgrant      = bgrant_q;
    assign msplit      = msplit_q;
    assign owner_id    = owner_q;
    assign bus_busy    = |bgrant_q;
    assign timeout_evt = tevt_q;

endmodule

// File: tb/tb_bus_arbiter_nm.sv
// Self-checking bench for bus_arbiter_nm: directed scenarios plus random
// traffic on a fixed-priority/timeout instance and a round-robin instance.
module tb_bus_arbiter_nm;

    typedef struct packed {
        int n;
        int rr;
        int tmo;
        int owner;    // -1 when the bus is idle
        int split_m;  // -1 when no split is outstanding
        int excl;     // -1 when nobody is excluded
        int ptr;
        int cnt;
        bit resume;
        bit tevt;
    } model_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] a_breq, a_bgrant, a_msplit;
    logic [1:0] a_owner;
    logic       a_busy, a_tevt, a_sreq, a_srel;
    logic [2:0] b_breq, b_bgrant, b_msplit;
    logic [1:0] b_owner;
    logic       b_busy, b_tevt, b_sreq, b_srel;

    logic [7:0] req_v[2];
    bit         sreq_v[2];
    bit         srel_v[2];
    int         len[2][8];
    model_t     mdl[2];

    int n_checks = 0;
    int n_fail   = 0;

    assign a_breq = req_v[0][3:0];
    assign b_breq = req_v[1][2:0];
    assign a_sreq = sreq_v[0];
    assign a_srel = srel_v[0];
    assign b_sreq = sreq_v[1];
    assign b_srel = srel_v[1];

    always #5 clk = ~clk;

    bus_arbiter_nm #(.NUM_MASTERS(4), .RR_MODE(0), .TIMEOUT(8)) u_dut_a (
        .clk(clk), .rst(rst), .breq(a_breq), .split_req(a_sreq), .split_release(a_srel),
        .bgrant(a_bgrant), .msplit(a_msplit), .owner_id(a_owner), .bus_busy(a_busy),
        .timeout_evt(a_tevt)
    );

    bus_arbiter_nm #(.NUM_MASTERS(3), .RR_MODE(1), .TIMEOUT(0)) u_dut_b (
        .clk(clk), .rst(rst), .breq(b_breq), .split_req(b_sreq), .split_release(b_srel),
        .bgrant(b_bgrant), .msplit(b_msplit), .owner_id(b_owner), .bus_busy(b_busy),
        .timeout_evt(b_tevt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic model_t model_init(input int n, input int rr, input int tmo);
        model_t m;
        m.n = n; m.rr = rr; m.tmo = tmo;
        m.owner = -1; m.split_m = -1; m.excl = -1;
        m.ptr = n - 1; m.cnt = 0; m.resume = 1'b0; m.tevt = 1'b0;
        return m;
    endfunction

    function automatic bit is_elig(input model_t m, input logic [7:0] req, input int c);
        return (req[c] == 1'b1) && (c != m.split_m) && (c != m.excl);
    endfunction

    // One clock of the arbitration rules, on integer owner/split indices.
    function automatic model_t model_step(input model_t m, input logic [7:0] req,
                                          input bit sreq, input bit srel);
        model_t r;
        bit     rel_ok;
        bit     others;
        int     w;
        int     c;
        r      = m;
        r.tevt = 1'b0;
        rel_ok = srel && (m.split_m >= 0);
        if (rel_ok) r.resume = 1'b1;
        if (m.owner < 0) begin
            if ((m.resume || rel_ok) && (m.split_m >= 0) && req[m.split_m]) begin
                r.owner = m.split_m; r.split_m = -1; r.resume = 1'b0; r.excl = -1; r.cnt = 0;
            end else begin
                w = -1;
                for (int k = 0; k < m.n; k++) begin
                    c = (m.rr != 0) ? (m.ptr + 1 + k) % m.n : k;
                    if (w < 0 && is_elig(m, req, c)) w = c;
                end
                if (w >= 0) begin
                    r.owner = w; r.excl = -1; r.cnt = 0;
                    if (m.rr != 0) r.ptr = w;
                end
            end
        end else begin
            others = 1'b0;
            for (int k = 0; k < m.n; k++)
                if (k != m.owner && is_elig(m, req, k)) others = 1'b1;
            if (sreq && m.split_m < 0) begin
                r.split_m = m.owner; r.owner = -1;
            end else if (!req[m.owner]) begin
                r.owner = -1;
            end else if (m.tmo > 0 && m.cnt == m.tmo - 1) begin
                r.tevt = 1'b1; r.excl = m.owner; r.owner = -1;
            end else if (others && m.cnt < m.tmo) begin
                r.cnt = m.cnt + 1;
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] exp_grant(input model_t m);
        return (m.owner >= 0) ? (32'd1 << m.owner) : 32'd0;
    endfunction

    function automatic logic [31:0] exp_split(input model_t m);
        return (m.split_m >= 0) ? (32'd1 << m.split_m) : 32'd0;
    endfunction

    function automatic logic [31:0] exp_owner(input model_t m);
        return (m.owner >= 0) ? 32'(m.owner) : 32'd0;
    endfunction

    task automatic compare_all();
        check("a_bgrant", 32'(a_bgrant), exp_grant(mdl[0]));
        check("a_msplit", 32'(a_msplit), exp_split(mdl[0]));
        check("a_owner",  32'(a_owner),  exp_owner(mdl[0]));
        check("a_busy",   32'(a_busy),   32'(mdl[0].owner >= 0));
        check("a_tevt",   32'(a_tevt),   32'(mdl[0].tevt));
        check("b_bgrant", 32'(b_bgrant), exp_grant(mdl[1]));
        check("b_msplit", 32'(b_msplit), exp_split(mdl[1]));
        check("b_owner",  32'(b_owner),  exp_owner(mdl[1]));
        check("b_busy",   32'(b_busy),   32'(mdl[1].owner >= 0));
        check("b_tevt",   32'(b_tevt),   32'(mdl[1].tevt));
    endtask

    task automatic tick();
        for (int d = 0; d < 2; d++)
            if (sreq_v[d] && mdl[d].split_m >= 0)
                $display("bench: dut%0d slave protocol error, split_req while a split is outstanding @%0t", d, $time);
        @(posedge clk);
        for (int d = 0; d < 2; d++) mdl[d] = model_step(mdl[d], req_v[d], sreq_v[d], srel_v[d]);
        #1;
        compare_all();
    endtask

    int hold, gap, n_own, got_idx, gcyc, evts, nm;
    bit prev_busy, seen;
    int exp_rr[4];

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            req_v[d] = '0; sreq_v[d] = 1'b0; srel_v[d] = 1'b0;
            for (int i = 0; i < 8; i++) len[d][i] = 0;
        end
        mdl[0] = model_init(4, 0, 8);
        mdl[1] = model_init(3, 1, 0);
        exp_rr = '{0, 1, 2, 0};
        repeat (2) @(posedge clk);
        #1;
        check("rst_a_bgrant", 32'(a_bgrant), 32'd0);
        check("rst_a_msplit", 32'(a_msplit), 32'd0);
        check("rst_a_owner",  32'(a_owner),  32'd0);
        check("rst_a_busy",   32'(a_busy),   32'd0);
        check("rst_a_tevt",   32'(a_tevt),   32'd0);
        check("rst_b_bgrant", 32'(b_bgrant), 32'd0);
        rst = 1'b0;

        // Fixed priority: lowest index wins, one dead cycle after release.
        req_v[0] = 8'b1010; tick();
        check("fp_first", 32'(a_bgrant), 32'b0010);
        tick();
        req_v[0] = 8'b1000; tick();
        check("fp_release", 32'(a_bgrant), 32'b0000);
        tick();
        check("fp_next", 32'(a_bgrant), 32'b1000);
        req_v[0] = '0; tick(); tick();

        // Split, illegal second split, resume ahead of a competing request.
        req_v[0] = 8'b0011; tick();
        check("sp_own0", 32'(a_bgrant), 32'b0001);
        sreq_v[0] = 1'b1; tick(); sreq_v[0] = 1'b0;
        check("sp_drop", 32'(a_bgrant), 32'b0000);
        check("sp_msplit", 32'(a_msplit), 32'b0001);
        tick();
        check("sp_m1", 32'(a_bgrant), 32'b0010);
        sreq_v[0] = 1'b1; tick(); sreq_v[0] = 1'b0;
        check("sp2_keep", 32'(a_bgrant), 32'b0010);
        check("sp2_msplit", 32'(a_msplit), 32'b0001);
        req_v[0] = 8'b0001; tick();
        check("sp_m1_rel", 32'(a_bgrant), 32'b0000);
        req_v[0] = 8'b0011; srel_v[0] = 1'b1; tick(); srel_v[0] = 1'b0;
        check("sp_resume", 32'(a_bgrant), 32'b0001);
        check("sp_msplit_clr", 32'(a_msplit), 32'b0000);
        req_v[0] = 8'b0010; tick(); tick();
        req_v[0] = '0; tick(); tick();

        // Timeout: master 0 revoked after 8 grant cycles, master 1 follows.
        req_v[0] = 8'b0011; tick();
        check("to_grant0", 32'(a_bgrant), 32'b0001);
        gcyc = 1; evts = 0; seen = 1'b0;
        for (int c = 0; c < 30 && !seen; c++) begin
            tick();
            if (a_tevt) begin
                evts++; seen = 1'b1;
                check("to_drop", 32'(a_bgrant), 32'b0000);
            end else if (a_bgrant == 4'b0001) begin
                gcyc++;
            end
        end
        check("to_seen", 32'(seen), 32'd1);
        check("to_len", 32'(gcyc), 32'd8);
        tick();
        check("to_m1", 32'(a_bgrant), 32'b0010);
        if (a_tevt) evts++;
        check("to_once", 32'(evts), 32'd1);
        req_v[0] = '0; tick(); tick();

        // Asynchronous reset while master 1 owns and master 0 is split.
        req_v[0] = 8'b0011; tick();
        sreq_v[0] = 1'b1; tick(); sreq_v[0] = 1'b0;
        tick();
        check("rm_pre_msplit", 32'(a_msplit), 32'b0001);
        #2 rst = 1'b1;
        #1;
        check("rm_bgrant", 32'(a_bgrant), 32'd0);
        check("rm_msplit", 32'(a_msplit), 32'd0);
        check("rm_owner",  32'(a_owner),  32'd0);
        check("rm_busy",   32'(a_busy),   32'd0);
        check("rm_tevt",   32'(a_tevt),   32'd0);
        mdl[0] = model_init(4, 0, 8);
        mdl[1] = model_init(3, 1, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        tick();
        check("rm_first", 32'(a_bgrant), 32'b0001);
        req_v[0] = '0; tick(); tick();

        // Round-robin: all request, 4-cycle transactions, order 0,1,2,0.
        hold = 0; gap = 0; n_own = 0; prev_busy = 1'b0;
        for (int c = 0; c < 60 && n_own < 4; c++) begin
            req_v[1] = 8'b0000_0111;
            if (mdl[1].owner >= 0 && hold >= 4) req_v[1][mdl[1].owner] = 1'b0;
            tick();
            if (mdl[1].owner >= 0) hold++; else hold = 0;
            if (b_bgrant != 3'b000 && !prev_busy) begin
                got_idx = -1;
                for (int i = 0; i < 3; i++) if (b_bgrant[i]) got_idx = i;
                check($sformatf("rr_order%0d", n_own), 32'(got_idx), 32'(exp_rr[n_own]));
                if (n_own > 0) check("rr_gap", 32'(gap), 32'd1);
                n_own++;
                gap = 0;
            end else if (b_bgrant == 3'b000) begin
                gap++;
            end
            prev_busy = |b_bgrant;
        end
        check("rr_done", 32'(n_own), 32'd4);
        req_v[1] = '0; tick(); tick();

        // Random traffic on both instances against the model.
        for (int c = 0; c < 600; c++) begin
            for (int d = 0; d < 2; d++) begin
                nm = (d == 0) ? 4 : 3;
                for (int i = 0; i < nm; i++) begin
                    if (!req_v[d][i]) begin
                        if ($urandom_range(0, 3) == 0) begin
                            req_v[d][i] = 1'b1;
                            len[d][i] = $urandom_range(1, 12);
                        end
                    end else if (mdl[d].owner == i) begin
                        if (len[d][i] == 0) req_v[d][i] = 1'b0;
                        else len[d][i]--;
                    end else if (mdl[d].split_m == i && $urandom_range(0, 15) == 0) begin
                        req_v[d][i] = 1'b0;
                    end
                end
                sreq_v[d] = (mdl[d].owner >= 0) && (mdl[d].split_m < 0) && ($urandom_range(0, 9) == 0);
                srel_v[d] = (mdl[d].split_m >= 0) ? ($urandom_range(0, 4) == 0)
                                                  : ($urandom_range(0, 29) == 0);
            end
            tick();
        end

        for (int d = 0; d < 2; d++) begin
            req_v[d] = '0; sreq_v[d] = 1'b0; srel_v[d] = 1'b0;
        end
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
